gemm_systolic_array: RTL and testbench
======================================

Name: gemm_systolic_array

Overview:
- 4x4 output-stationary systolic MAC array for the GEMM datapath.
- Consumes the skewed, zero-padded operand streams from the A-matrix feeder (rows, a_in0..3) and the B-matrix feeder (columns, b_in0..3), and accumulates C = A x B in-place.
- Then drains C one row per transfer over a valid/ready handshake to the result writer.

Parameters:
- DATA_W, 32, operand width (signed two's-complement).
- ACC_W, 32, accumulator and result width; products and sums are truncated to ACC_W LSBs.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, asserted in the same cycle the feeders' rden first goes high.
- a_in0..a_in3  in  DATA_W each  A-row streams; a_in_i is already skewed by i cycles and is 0 when idle.
- b_in0..b_in3  in  DATA_W each  B-column streams; b_in_j is already skewed by j cycles and is 0 when idle.
- busy  out  1  high in COMPUTE and DRAIN.
- out_valid  out  1  a result row is presented.
- out_ready  in  1  consumer accepts the row.
- out_row  out  2  index of the presented row.
- c0..c3  out  ACC_W each  C[out_row][0..3].
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset: state=IDLE; all accumulators, forwarding registers and the cycle counter are 0; busy, out_valid and done are 0; out_row=0; c0..c3=0.
- IDLE:
  - start=1 -> clear every accumulator and forwarding register, counter<=0, go to COMPUTE.
  - Inputs are ignored in IDLE.
- PE(i,j):
  - a operand: i==0... column 0 uses a_in_i; otherwise a_reg of PE(i,j-1).
  - b operand: row 0 uses b_in_j; otherwise b_reg of PE(i-1,j).
  - Every cycle: a_reg<=a operand, b_reg<=b operand.
  - In COMPUTE only: acc<=acc+trunc(a*b).
- COMPUTE:
  - Lasts exactly 3N-2 = 10 cycles: the 10 cycles immediately after the start cycle; counter runs 0..9.
  - With feeders registering one cycle after rden, the k-th product for PE(i,j) arrives in COMPUTE cycle k+i+j. The last product (PE(3,3), k=3) lands in cycle 9.
  - After counter==9 -> DRAIN; out_row<=0.
- DRAIN:
  - out_valid=1; c0..c3 show acc[out_row][0..3] combinationally from the frozen accumulators.
  - out_valid && out_ready -> out_row increments.
  - Transfer with out_row==3 -> IDLE, done=1 for one cycle, out_valid=0.
  - out_ready=0 -> out_row and c0..c3 hold stable indefinitely.
- start while busy: ignored, no effect on state or data.
- start and the final DRAIN transfer in the same cycle: start is ignored; the bench re-issues it.
- rst at any time, including mid-COMPUTE or mid-DRAIN: everything returns to reset values next cycle; no partial done pulse.
- Arithmetic:
  - Signed DATA_W x DATA_W multiply, sign-extended or truncated to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation, no overflow flag.
- Latency: start to first out_valid = 11 cycles. start to done = 15 cycles with out_ready held high.

Decomposition:
- Package gemm_pkg holds:
  - N=4
  - default DATA_W/ACC_W
  - COMPUTE_CYCLES = 3*N-2
  - state typedef enum {IDLE, COMPUTE, DRAIN}
  - typedef for the row-index width (clog2 N).
- Sub-module gemm_pe: one processing element.
  - Ports: clk, rst, clr, acc_en, a_in, b_in, a_out, b_out, acc.
  - Instantiated N x N in a generate loop.
  - Control FSM and drain mux stay in gemm_systolic_array.

Test Plan:
- Identity x counting: A=I, B[r][c]=4r+c (0x0..0xF), correctly skewed streams -> rows 0..3 = {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}; out_valid first at start+11; done at start+15.
- All-ones A, same B -> every row = {24,28,32,36}.
- Wrap and sign, other entries 0:
  - A[0][0]=B[0][0]=0x00010000 -> C[0][0]=0x00000000.
  - A[1][0]=0xFFFFFFFF, B[0][1]=2 -> C[1][1]=0xFFFFFFFE.
- Backpressure: out_ready low for 5 cycles on row 1 -> out_row=1 and c0..c3 stable throughout; then rows 2, 3 delivered; done only after row 3 accepted.
- start pulsed at start+4 and again mid-DRAIN -> no restart; results identical to the first scenario; single done pulse.
- rst asserted at start+6 -> next cycle busy=0, out_valid=0, accumulators 0. A fresh start with the all-ones case yields {24,28,32,36} with no residue.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared sizing, state encoding and index types for the 4x4 output-stationary GEMM array.
package gemm_pkg;

   localparam int N              = 4;
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ACC_W  = 32;
   localparam int COMPUTE_CYCLES = 3 * N - 2;
   localparam int ROW_W          = $clog2(N);
   localparam int CNT_W          = $clog2(COMPUTE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DRAIN
   } state_t;

   typedef logic [ROW_W-1:0] row_t;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/gemm_pe.sv
// One processing element: forwards a east and b south, accumulates a*b modulo 2^ACC_W.
module gemm_pe #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              acc_en,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc
);

   // Only the low ACC_W bits survive, so multiplying at ACC_W width after sign
   // extension gives the same result as the full-width signed product.
   logic signed [ACC_W-1:0] a_w;
   logic signed [ACC_W-1:0] b_w;
   logic signed [ACC_W-1:0] prod;

   assign a_w  = ACC_W'($signed(a_in));
   assign b_w  = ACC_W'($signed(b_in));
   assign prod = a_w * b_w;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         if (acc_en) begin
            acc <= acc + prod;
         end
      end
   end

endmodule

// File: rtl/gemm_systolic_array.sv
// 4x4 output-stationary systolic MAC array: accumulates skewed A/B streams, then drains C row by row.
module gemm_systolic_array
   import gemm_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ACC_W  = DEFAULT_ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a_in0,
   input  logic [DATA_W-1:0] a_in1,
   input  logic [DATA_W-1:0] a_in2,
   input  logic [DATA_W-1:0] a_in3,
   input  logic [DATA_W-1:0] b_in0,
   input  logic [DATA_W-1:0] b_in1,
   input  logic [DATA_W-1:0] b_in2,
   input  logic [DATA_W-1:0] b_in3,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_row,
   output logic [ACC_W-1:0]  c0,
   output logic [ACC_W-1:0]  c1,
   output logic [ACC_W-1:0]  c2,
   output logic [ACC_W-1:0]  c3,
   output logic              done
);

   localparam cnt_t LAST_CNT = cnt_t'(COMPUTE_CYCLES - 1);
   localparam row_t LAST_ROW = row_t'(N - 1);

   state_t state;
   cnt_t   cnt;
   row_t   row;
   logic   clr;
   logic   acc_en;

   logic [DATA_W-1:0] a_edge [N];
   logic [DATA_W-1:0] b_edge [N];
   logic [DATA_W-1:0] a_fwd  [N][N];
   logic [DATA_W-1:0] b_fwd  [N][N];
   logic [ACC_W-1:0]  acc_q  [N][N];

   assign a_edge[0] = a_in0;
   assign a_edge[1] = a_in1;
   assign a_edge[2] = a_in2;
   assign a_edge[3] = a_in3;
   assign b_edge[0] = b_in0;
   assign b_edge[1] = b_in1;
   assign b_edge[2] = b_in2;
   assign b_edge[3] = b_in3;

   assign clr    = (state == IDLE) && start;
   assign acc_en = (state == COMPUTE);

   // Operands enter on the west/north edges and hop one PE per cycle.
   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         logic [DATA_W-1:0] a_op;
         logic [DATA_W-1:0] b_op;

         if (gj == 0) begin : g_a_edge
            assign a_op = a_edge[gi];
         end else begin : g_a_fwd
            assign a_op = a_fwd[gi][gj-1];
         end

         if (gi == 0) begin : g_b_edge
            assign b_op = b_edge[gj];
         end else begin : g_b_fwd
            assign b_op = b_fwd[gi-1][gj];
         end

         gemm_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .acc_en (acc_en),
            .a_in   (a_op),
            .b_in   (b_op),
            .a_out  (a_fwd[gi][gj]),
            .b_out  (b_fwd[gi][gj]),
            .acc    (acc_q[gi][gj])
         );
      end
   end

   // A start that coincides with the final drain transfer is dropped, since state is still DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         row   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  cnt   <= '0;
                  state <= COMPUTE;
               end
            end
            COMPUTE: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  row   <= '0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (row == LAST_ROW) begin
                     row   <= '0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     row <= row + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == DRAIN);
   assign out_row   = row;

   always_comb begin
      c0 = '0;
      c1 = '0;
      c2 = '0;
      c3 = '0;
      if (state == DRAIN) begin
         c0 = acc_q[row][0];
         c1 = acc_q[row][1];
         c2 = acc_q[row][2];
         c3 = acc_q[row][3];
      end
   end

endmodule

// File: tb/tb_gemm_systolic_array.sv
// Directed bench for gemm_systolic_array: skewed operand feeding, drain handshake, reset and start corner cases.
module tb_gemm_systolic_array;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        out_ready;
   logic [31:0] a_drv [4];
   logic [31:0] b_drv [4];
   logic        busy;
   logic        out_valid;
   logic        done;
   logic [1:0]  out_row;
   logic [31:0] c0, c1, c2, c3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;

   logic [31:0] ma    [4][4];
   logic [31:0] mb    [4][4];
   logic [31:0] exp_c [4][4];

   gemm_systolic_array #(
      .DATA_W (32),
      .ACC_W  (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a_in0     (a_drv[0]),
      .a_in1     (a_drv[1]),
      .a_in2     (a_drv[2]),
      .a_in3     (a_drv[3]),
      .b_in0     (b_drv[0]),
      .b_in1     (b_drv[1]),
      .b_in2     (b_drv[2]),
      .b_in3     (b_drv[3]),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .c0        (c0),
      .c1        (c1),
      .c2        (c2),
      .c3        (c3),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 4; i++) begin
         a_drv[i] = '0;
         b_drv[i] = '0;
      end
   endtask

   // Compute cycle t: row i carries A[i][t-i], column j carries B[t-j][j].
   task automatic feed(input int t);
      for (int i = 0; i < 4; i++) begin
         int k;
         k = t - i;
         a_drv[i] = (k >= 0 && k < 4) ? ma[i][k] : 32'h0;
         b_drv[i] = (k >= 0 && k < 4) ? mb[k][i] : 32'h0;
      end
   endtask

   task automatic set_identity_count();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            ma[r][c]    = (r == c) ? 32'h1 : 32'h0;
            mb[r][c]    = 32'(4 * r + c);
            exp_c[r][c] = 32'(4 * r + c);
         end
      end
   endtask

   task automatic set_all_ones();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            ma[r][c]    = 32'h1;
            mb[r][c]    = 32'(4 * r + c);
            exp_c[r][c] = 32'(24 + 4 * c);
         end
      end
   endtask

   task automatic set_wrap_sign();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            ma[r][c]    = 32'h0;
            mb[r][c]    = 32'h0;
            exp_c[r][c] = 32'h0;
         end
      end
      ma[0][0] = 32'h0001_0000;
      mb[0][0] = 32'h0001_0000;
      ma[1][0] = 32'hFFFF_FFFF;
      mb[0][1] = 32'h0000_0002;
      exp_c[0][0] = 32'h0000_0000;
      exp_c[0][1] = 32'h0002_0000;
      exp_c[1][0] = 32'hFFFF_0000;
      exp_c[1][1] = 32'hFFFF_FFFE;
   endtask

   // Leaves the bench one cycle into DRAIN, where row 0 should first appear.
   task automatic run_compute(input int extra_start_t);
      step();
      clear_inputs();
      start     = 1'b1;
      start_cyc = cyc;
      for (int t = 0; t < 10; t++) begin
         step();
         start = (t == extra_start_t);
         feed(t);
         if (t == 9) begin
            checks++;
            if ({busy, out_valid} !== 2'b10) begin
               errors++;
               $display("[TB] FAIL compute_flags: busy/out_valid got %b expected 10", {busy, out_valid});
            end
         end
      end
      step();
      start = 1'b0;
      clear_inputs();
      checks++;
      if (out_valid !== 1'b1 || (cyc - start_cyc) != 11) begin
         errors++;
         $display("[TB] FAIL first_valid: out_valid %b after %0d cycles expected 1 after 11",
                  out_valid, cyc - start_cyc);
      end
   endtask

   task automatic drain_check(input int stall_row, input int stall_cycles, input bit start_on_last);
      for (int r = 0; r < 4; r++) begin
         out_ready = 1'b1;
         checks++;
         if (out_valid !== 1'b1 || out_row !== 2'(r) || done !== 1'b0 ||
             {c0, c1, c2, c3} !== {exp_c[r][0], exp_c[r][1], exp_c[r][2], exp_c[r][3]}) begin
            errors++;
            $display("[TB] FAIL row%0d: valid %b row %0d done %b c %h %h %h %h expected row %0d c %h %h %h %h",
                     r, out_valid, out_row, done, c0, c1, c2, c3, r,
                     exp_c[r][0], exp_c[r][1], exp_c[r][2], exp_c[r][3]);
         end
         if (r == stall_row) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               step();
               checks++;
               if (out_valid !== 1'b1 || out_row !== 2'(r) || done !== 1'b0 ||
                   {c0, c1, c2, c3} !== {exp_c[r][0], exp_c[r][1], exp_c[r][2], exp_c[r][3]}) begin
                  errors++;
                  $display("[TB] FAIL stall%0d: valid %b row %0d c %h %h %h %h expected row %0d held",
                           s, out_valid, out_row, c0, c1, c2, c3, r);
               end
            end
            out_ready = 1'b1;
         end
         if (r == 3 && start_on_last) start = 1'b1;
         step();
         start = 1'b0;
      end
      checks++;
      if ({done, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL done_pulse: done/valid/busy got %b expected 100", {done, out_valid, busy});
      end
      if (stall_row < 0) begin
         checks++;
         if ((cyc - start_cyc) != 15) begin
            errors++;
            $display("[TB] FAIL done_latency: got %0d cycles expected 15", cyc - start_cyc);
         end
      end
      step();
      checks++;
      if ({done, busy, out_valid} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL after_done: done/busy/valid got %b expected 000", {done, busy, out_valid});
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b1;
      clear_inputs();
      step();
      step();
      rst = 1'b0;
      checks++;
      if ({busy, out_valid, done, out_row} !== 5'b0 || {c0, c1, c2, c3} !== 128'h0) begin
         errors++;
         $display("[TB] FAIL reset_state: busy %b valid %b done %b row %0d c %h %h %h %h expected all 0",
                  busy, out_valid, done, out_row, c0, c1, c2, c3);
      end
      // Inputs alone must not wake the array.
      a_drv[0] = 32'h5;
      b_drv[0] = 32'h7;
      step();
      clear_inputs();
      checks++;
      if ({busy, out_valid, done} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL idle_ignore: busy/valid/done got %b expected 000", {busy, out_valid, done});
      end
   endtask

   task automatic test_identity();
      set_identity_count();
      run_compute(-1);
      drain_check(-1, 0, 1'b0);
   endtask

   task automatic test_all_ones();
      set_all_ones();
      run_compute(-1);
      drain_check(-1, 0, 1'b0);
   endtask

   task automatic test_wrap_sign();
      set_wrap_sign();
      run_compute(-1);
      drain_check(-1, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      set_identity_count();
      run_compute(-1);
      drain_check(1, 5, 1'b0);
   endtask

   task automatic test_start_while_busy();
      set_identity_count();
      run_compute(3);
      drain_check(-1, 0, 1'b1);
   endtask

   task automatic test_reset_mid_compute();
      logic [31:0] acc_or;
      set_identity_count();
      step();
      clear_inputs();
      start = 1'b1;
      for (int t = 0; t < 6; t++) begin
         step();
         start = 1'b0;
         feed(t);
         if (t == 5) rst = 1'b1;
      end
      step();
      rst = 1'b0;
      clear_inputs();
      acc_or = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            acc_or = acc_or | dut.acc_q[i][j];
         end
      end
      checks++;
      if ({busy, out_valid, done} !== 3'b000 || acc_or !== 32'h0) begin
         errors++;
         $display("[TB] FAIL mid_reset: busy/valid/done %b acc_or %h expected 000 and 0",
                  {busy, out_valid, done}, acc_or);
      end
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL mid_reset_done: busy/done got %b expected 00", {busy, done});
      end
      set_all_ones();
      run_compute(-1);
      drain_check(-1, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_all_ones();
      test_wrap_sign();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_compute();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
